// File: rtl/i2c_bit_sequencer.sv
// I2C bit-level sequencer: runs one bus primitive (START/STOP/WRITE/READ) as four quarter-phases
// of Q clk cycles each, driving open-drain release levels and honouring clock stretching in PH_B.
module i2c_bit_sequencer #(
  parameter int DIV_W   = 10,
  parameter int DIV_MIN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd,
  input  logic             cmd_din,
  output logic             done,
  output logic             dout,
  output logic             busy,
  output logic             scl_o,
  output logic             sda_o,
  input  logic             scl_i,
  input  logic             sda_i
);
  typedef enum logic [2:0] {IDLE, PH_A, PH_B, PH_C, PH_D} state_t;

  localparam logic [1:0]       CMD_START = 2'b00;
  localparam logic [1:0]       CMD_STOP  = 2'b01;
  localparam logic [1:0]       CMD_WRITE = 2'b10;
  localparam logic [1:0]       CMD_READ  = 2'b11;
  localparam logic [DIV_W-1:0] Q_MIN     = DIV_W'(DIV_MIN);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] q_q, q_d;
  logic [1:0]       cmd_q, cmd_d;
  logic             din_q, din_d;
  logic             samp_q, samp_d;
  logic             dout_q, dout_d;
  logic             done_q, done_d;
  logic             scl_q, scl_d;
  logic             sda_q, sda_d;
  logic             stall, last;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign dout      = dout_q;
  assign scl_o     = scl_q;
  assign sda_o     = sda_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    cmd_d   = cmd_q;
    din_d   = din_q;
    samp_d  = samp_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    // A slave holding SCL low while we release it freezes the PH_B count.
    stall   = (state_q == PH_B) && scl_q && !scl_i;
    last    = (cnt_q == q_q - DIV_W'(1));

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = PH_A;
          cnt_d   = '0;
          q_d     = (div < Q_MIN) ? Q_MIN : div;
          cmd_d   = cmd;
          din_d   = cmd_din;
        end
      end
      PH_A, PH_B, PH_C, PH_D: begin
        if (!stall) begin
          if (last) begin
            cnt_d = '0;
            case (state_q)
              PH_A: state_d = PH_B;
              PH_B: state_d = PH_C;
              PH_C: begin
                state_d = PH_D;
                samp_d  = sda_i;
              end
              default: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (cmd_q == CMD_READ) dout_d = samp_q;
              end
            endcase
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so levels are chosen for the state being entered.
    scl_d = scl_q;
    sda_d = sda_q;
    case (state_d)
      PH_A: begin
        case (cmd_d)
          CMD_START: sda_d = 1'b1;
          CMD_STOP:  {scl_d, sda_d} = 2'b00;
          CMD_WRITE: {scl_d, sda_d} = {1'b0, din_d};
          default:   {scl_d, sda_d} = 2'b01;
        endcase
      end
      PH_B: begin
        case (cmd_d)
          CMD_START: {scl_d, sda_d} = 2'b11;
          CMD_STOP:  {scl_d, sda_d} = 2'b10;
          CMD_WRITE: {scl_d, sda_d} = {1'b1, din_d};
          default:   {scl_d, sda_d} = 2'b11;
        endcase
      end
      PH_C: begin
        case (cmd_d)
          CMD_START: {scl_d, sda_d} = 2'b10;
          CMD_STOP:  {scl_d, sda_d} = 2'b11;
          CMD_WRITE: {scl_d, sda_d} = {1'b1, din_d};
          default:   {scl_d, sda_d} = 2'b11;
        endcase
      end
      PH_D: begin
        case (cmd_d)
          CMD_START: {scl_d, sda_d} = 2'b00;
          CMD_STOP:  {scl_d, sda_d} = 2'b11;
          CMD_WRITE: {scl_d, sda_d} = {1'b0, din_d};
          default:   {scl_d, sda_d} = 2'b01;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      cmd_q   <= CMD_START;
      din_q   <= 1'b0;
      samp_q  <= 1'b0;
      dout_q  <= 1'b0;
      done_q  <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      cmd_q   <= cmd_d;
      din_q   <= din_d;
      samp_q  <= samp_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
    end
  end
endmodule

// File: tb/tb_i2c_bit_sequencer.sv
// Self-checking bench for i2c_bit_sequencer: directed vector table, reset and back-to-back
// sequences, then random commands checked cycle by cycle against a phase-table reference model.
module tb_i2c_bit_sequencer;
  localparam int DIV_W = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic [DIV_W-1:0] div;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd;
  logic             cmd_din;
  logic             done;
  logic             dout;
  logic             busy;
  logic             scl_o;
  logic             sda_o;
  logic             scl_i;
  logic             sda_i;

  i2c_bit_sequencer #(.DIV_W(DIV_W), .DIV_MIN(2)) dut (
    .clk(clk), .rst(rst), .div(div), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .cmd_din(cmd_din), .done(done), .dout(dout), .busy(busy),
    .scl_o(scl_o), .sda_o(sda_o), .scl_i(scl_i), .sda_i(sda_i)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_scl, exp_sda, exp_dout;

  typedef struct {
    logic [1:0] c;
    logic       d;
    int         dv;
    int         s;
    int         sda_fix;
    bit         hold;
    int         exp_lat;
    int         exp_scl_hi;
    bit         chk_dout;
    logic       exp_dout;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Bus levels {scl,sda} by command and phase (0=A..3=D).
  function automatic logic [1:0] lvl(input logic [1:0] c, input int p, input logic d,
                                     input logic prev_scl);
    logic hi;
    hi = (p == 1) || (p == 2);
    case (c)
      2'b00: begin
        case (p)
          0: return {prev_scl, 1'b1};
          1: return 2'b11;
          2: return 2'b10;
          default: return 2'b00;
        endcase
      end
      2'b01: begin
        case (p)
          0: return 2'b00;
          1: return 2'b10;
          default: return 2'b11;
        endcase
      end
      2'b10:   return {hi, d};
      default: return {hi, 1'b1};
    endcase
  endfunction

  // Called at the negedge of the accept cycle; returns at the negedge of the done cycle.
  task automatic run_cmd(input logic [1:0] c, input logic d, input int dv, input int s,
                         input int sda_fix, input bit hold,
                         output int first_done, output int scl_hi);
    int         q, len, samp_k, p;
    logic       samp;
    logic [1:0] lv;
    q      = (dv < 2) ? 2 : dv;
    len    = 4 * q + s;
    samp_k = 3 * q + s;
    samp   = 1'b0;
    first_done = 0;
    scl_hi     = 0;
    chk("ready_at_accept", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd       = c;
    cmd_din   = d;
    div       = DIV_W'(dv);
    scl_i     = 1'b1;
    sda_i     = (sda_fix < 0) ? 1'($urandom_range(0, 1)) : 1'(sda_fix);
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      if (k <= len) begin
        p  = (k <= q) ? 0 : (k <= 2 * q + s) ? 1 : (k <= 3 * q + s) ? 2 : 3;
        lv = lvl(c, p, d, exp_scl);
        exp_scl = lv[1];
        exp_sda = lv[0];
      end else if (c == 2'b11) begin
        exp_dout = samp;
      end
      chk("scl_o", scl_o, exp_scl);
      chk("sda_o", sda_o, exp_sda);
      chk("busy", busy, (k <= len) ? 1 : 0);
      chk("done", done, (k == len + 1) ? 1 : 0);
      chk("cmd_ready", cmd_ready, (k > len) ? 1 : 0);
      chk("dout", dout, exp_dout);
      if (done && first_done == 0) first_done = k;
      if (k <= len && scl_o) scl_hi++;
      if (hold && k <= len) begin
        cmd_valid = 1'b1;
        cmd       = 2'($urandom_range(0, 3));
        cmd_din   = 1'($urandom_range(0, 1));
        div       = DIV_W'($urandom_range(0, 20));
      end else begin
        cmd_valid = 1'b0;
      end
      scl_i = (k >= q + 1 && k <= q + s) ? 1'b0 : 1'b1;
      sda_i = (sda_fix < 0) ? 1'($urandom_range(0, 1)) : 1'(sda_fix);
      if (k == samp_k) samp = sda_i;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_scl", scl_o, exp_scl);
      chk("idle_sda", sda_o, exp_sda);
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_ready", cmd_ready, 1);
      chk("idle_dout", dout, exp_dout);
      cmd_valid = 1'b0;
      scl_i     = 1'b1;
      sda_i     = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    vec_t vecs[8];
    int   fd, hi;

    vecs[0] = '{2'b00, 1'b0, 0, 0,  -1, 1'b0,  9,  6, 1'b0, 1'b0};
    vecs[1] = '{2'b10, 1'b0, 4, 0,  -1, 1'b1, 17,  8, 1'b0, 1'b0};
    vecs[2] = '{2'b11, 1'b0, 4, 0,   0, 1'b0, 17,  8, 1'b1, 1'b0};
    vecs[3] = '{2'b11, 1'b0, 4, 0,   1, 1'b0, 17,  8, 1'b1, 1'b1};
    vecs[4] = '{2'b10, 1'b1, 4, 10, -1, 1'b0, 27, 18, 1'b0, 1'b0};
    vecs[5] = '{2'b01, 1'b0, 1, 0,  -1, 1'b0,  9,  6, 1'b0, 1'b0};
    vecs[6] = '{2'b11, 1'b0, 3, 0,   0, 1'b0, 13,  6, 1'b1, 1'b0};
    vecs[7] = '{2'b10, 1'b1, 5, 3,  -1, 1'b0, 24, 13, 1'b0, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; cmd_din = 1'b0; div = '0;
    scl_i = 1'b1; sda_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_scl", scl_o, 1);
    chk("rst_sda", sda_o, 1);
    chk("rst_done", done, 0);
    chk("rst_dout", dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    exp_scl = 1'b1; exp_sda = 1'b1; exp_dout = 1'b0;

    // Table vectors run back to back: each accept lands in the previous done cycle.
    for (int i = 0; i < 8; i++) begin
      run_cmd(vecs[i].c, vecs[i].d, vecs[i].dv, vecs[i].s, vecs[i].sda_fix, vecs[i].hold, fd, hi);
      chk("vec_latency", fd, vecs[i].exp_lat);
      chk("vec_scl_high", hi, vecs[i].exp_scl_hi);
      if (vecs[i].chk_dout) chk("vec_dout", dout, vecs[i].exp_dout);
    end

    // Reset in the middle of PH_B of a WRITE.
    idle(2);
    cmd_valid = 1'b1; cmd = 2'b10; cmd_din = 1'b0; div = DIV_W'(4);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    chk("midcmd_busy", busy, 1);
    chk("midcmd_scl", scl_o, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_scl", scl_o, 1);
    chk("rst_mid_sda", sda_o, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", cmd_ready, 1);
    chk("rst_mid_done", done, 0);
    exp_scl = 1'b1; exp_sda = 1'b1; exp_dout = 1'b0;
    idle(20);

    for (int i = 0; i < 60; i++) begin
      run_cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 6),
              $urandom_range(0, 5), -1, ($urandom_range(0, 3) == 0), fd, hi);
      idle($urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
